// File: rtl/mac_gated_row_if.sv
// Request/response bundle between the upstream input pipeline and mac_gated_row.
interface mac_gated_row_if;
  logic [63:0] in_in;         // eight byte lanes: weights on load, activations on execute
  logic [1:0]  inst_in;       // [1] execute, [0] load
  logic [7:0]  q_zero_in;     // per-lane activation-is-zero flag
  logic [23:0] psum_out;      // signed accumulated partial sum
  logic        psum_valid;    // one-cycle pulse when psum_out updates
  logic [3:0]  lanes_active;  // enabled lanes of the last accepted execute
  logic [15:0] gated_cnt;     // saturating count of skipped lane-cycles
  logic        err;           // sticky protocol error

  modport master (
    output in_in, inst_in, q_zero_in,
    input  psum_out, psum_valid, lanes_active, gated_cnt, err
  );

  modport slave (
    input  in_in, inst_in, q_zero_in,
    output psum_out, psum_valid, lanes_active, gated_cnt, err
  );
endinterface

// File: rtl/mac_gated_row.sv
// Eight-lane zero-gated MAC row: per-lane weight/product registers plus a
// two-stage reduce/accumulate pipeline under a three-state control FSM.

// One lane: holds a signed weight, its zero flag, and the stage-1 product.
module mac_gated_row_lane (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,   // latch i_data as the weight
  input  logic               i_exec,   // accepted execute this edge
  input  logic [7:0]         i_data,
  input  logic               i_qz,     // activation flagged zero upstream
  output logic               o_en,     // lane participates in this execute
  output logic signed [16:0] o_pm      // masked stage-1 product
);
  logic signed [7:0]  r_w;
  logic               r_wz;
  logic signed [16:0] r_p;
  logic               r_m;
  logic signed [16:0] w_a;
  logic signed [16:0] w_b;
  logic signed [16:0] w_prod;

  // Unsigned activation times signed weight; 17 bits holds every result.
  assign w_a    = {9'b0, i_data};
  assign w_b    = {{9{r_w[7]}}, r_w};
  assign w_prod = w_a * w_b;

  // Upstream zero flag is trusted over the actual byte value.
  assign o_en = !i_qz && !r_wz;

  // Weight and its zero flag, captured on load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w  <= '0;
      r_wz <= 1'b0;
    end else if (i_load) begin
      r_w  <= i_data;
      r_wz <= (i_data == 8'h00);
    end
  end

  // Product only toggles for enabled lanes; disabled lanes hold and get masked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p <= '0;
      r_m <= 1'b0;
    end else if (i_exec) begin
      r_m <= o_en;
      if (o_en) r_p <= w_prod;
    end
  end

  assign o_pm = r_m ? r_p : '0;
endmodule

// Row top: control FSM, lane array, reduction and accumulator.
module mac_gated_row (
  input  logic            clk,
  input  logic            reset,
  mac_gated_row_if.slave  bus
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int PROD_W    = 17;
  localparam int SUM_W     = 20;
  localparam int PSUM_W    = 24;

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_ACC} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_load;       // load accepted (2'b11 is execute-only)
  logic w_exec_ok;    // execute accepted (weights present)
  logic w_first;      // execute opens a fresh accumulation
  logic w_err_set;    // protocol violation this cycle

  logic [NUM_LANES-1:0]             w_en;
  logic [NUM_LANES-1:0][PROD_W-1:0] w_pm;
  logic [3:0]                       w_cnt;
  logic signed [SUM_W-1:0]          w_sum;
  logic [16:0]                      w_gated_nxt;

  logic [1:0]        r_vld_pipe;   // [0] products registered, [1] psum_valid
  logic              r_first;      // first-since-load flag riding with stage 1
  logic [PSUM_W-1:0] r_psum;
  logic [3:0]        r_lanes;
  logic [15:0]       r_gated;
  logic              r_err;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // FSM next state: load always re-arms, first execute opens accumulation.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_READY;
      S_READY: if (w_load) w_state_nxt = S_READY;
               else if (w_exec_ok) w_state_nxt = S_ACC;
      S_ACC:   if (w_load) w_state_nxt = S_READY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // FSM outputs: instruction decode qualified by state.
  always_comb begin
    w_load    = (bus.inst_in == 2'b01);
    w_exec_ok = bus.inst_in[1] && (r_state != S_EMPTY);
    w_first   = (r_state == S_READY);
    w_err_set = (bus.inst_in == 2'b11) || (bus.inst_in[1] && (r_state == S_EMPTY));
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mac_gated_row_lane u_lane (
      .clk    (clk),
      .rst    (reset),
      .i_load (w_load),
      .i_exec (w_exec_ok),
      .i_data (bus.in_in[VEC_W*g +: VEC_W]),
      .i_qz   (bus.q_zero_in[g]),
      .o_en   (w_en[g]),
      .o_pm   (w_pm[g])
    );
  end

  // Count of lanes enabled for the execute on the bus.
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < NUM_LANES; i++) w_cnt = w_cnt + {3'b0, w_en[i]};
  end

  // Reduction of masked stage-1 products, sign-extended to 20 bits.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_LANES; i++)
      w_sum = w_sum + {{(SUM_W-PROD_W){w_pm[i][PROD_W-1]}}, w_pm[i]};
  end

  assign w_gated_nxt = {1'b0, r_gated} + {13'b0, 4'd8 - w_cnt};

  // Stage 1 bookkeeping: valid shift, first flag, lane stats, gating count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_first    <= 1'b0;
      r_lanes    <= '0;
      r_gated    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_exec_ok};
      if (w_exec_ok) begin
        r_first <= w_first;
        r_lanes <= w_cnt;
        r_gated <= w_gated_nxt[16] ? 16'hFFFF : w_gated_nxt[15:0];
      end
    end
  end

  // Stage 2: restart or accumulate with plain 24-bit wraparound.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_psum <= '0;
    end else if (r_vld_pipe[0]) begin
      if (r_first) r_psum <= {{(PSUM_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
      else         r_psum <= r_psum + {{(PSUM_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};
    end
  end

  // Sticky protocol error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign bus.psum_out     = r_psum;
  assign bus.psum_valid   = r_vld_pipe[1];
  assign bus.lanes_active = r_lanes;
  assign bus.gated_cnt    = r_gated;
  assign bus.err          = r_err;
endmodule
